// File: rtl/router_pkg.sv
// ============================================================================
// router_pkg : shared constants and helpers for the 1x3 router
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

package router_pkg;

  localparam int ROUTER_WIDTH      = 8;
  localparam int ROUTER_FIFO_DEPTH = 16;
  localparam int LEN_MSB           = 7;
  localparam int LEN_LSB           = 2;
  localparam int PKT_CNT_W         = 7;

  // Header length field plus the trailing parity byte.
  function automatic logic [PKT_CNT_W-1:0] hdr_count(input logic [LEN_MSB-LEN_LSB:0] len);
    return PKT_CNT_W'(len) + PKT_CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/router_fifo_mem.sv
// ============================================================================
// router_fifo_mem : register array, synchronous write, asynchronous read
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module router_fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/router_fifo.sv
// ============================================================================
// router_fifo : per-port output FIFO with header-driven packet byte counter
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module router_fifo
  import router_pkg::*;
#(
  parameter int WIDTH = ROUTER_WIDTH,
  parameter int DEPTH = ROUTER_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 soft_rst,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic                 lfd_state,
  input  logic [WIDTH-1:0]     data_in,
  output logic [WIDTH-1:0]     data_out,
  output logic                 full,
  output logic                 empty,
  output logic [PKT_CNT_W-1:0] pkt_rem
);

  logic [AW:0]    r_wr_ptr, r_rd_ptr;
  logic [WIDTH:0] w_rd_entry;
  logic           w_clr, w_wr_ok, w_rd_ok;

  assign w_clr   = !rst || soft_rst;
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr_ok = wr_en && !full && !w_clr;
  assign w_rd_ok = rd_en && !empty && !w_clr;

  router_fifo_mem #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (w_wr_ok),
    .waddr (r_wr_ptr[AW-1:0]),
    .wdata ({lfd_state, data_in}),
    .raddr (r_rd_ptr[AW-1:0]),
    .rdata (w_rd_entry)
  );

  // Bit WIDTH of each entry marks a header; reading one reloads the byte count.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      data_out <= '0;
      pkt_rem  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        data_out <= w_rd_entry[WIDTH-1:0];
        if (w_rd_entry[WIDTH])
          pkt_rem <= hdr_count(w_rd_entry[LEN_MSB:LEN_LSB]);
        else if (pkt_rem != '0)
          pkt_rem <= pkt_rem - PKT_CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_router_fifo.sv
// ============================================================================
// tb_router_fifo : randomized self-checking bench against a queue model
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module tb_router_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       soft_rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       full, empty;
  logic [6:0] pkt_rem;

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents as {header flag, byte}
  logic [8:0] q[$];
  logic [7:0] m_dout = '0;
  int         m_rem  = 0;

  router_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .soft_rst  (soft_rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .lfd_state (lfd_state),
    .data_in   (data_in),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .pkt_rem   (pkt_rem)
  );

  always #5 clk = ~clk;

  // Apply inputs for one cycle, advance the model at the edge, settle 1ns later.
  task automatic step(input logic w, input logic r, input logic l, input logic [7:0] d);
    logic       do_rd, do_wr;
    logic [8:0] e;
    wr_en = w; rd_en = r; lfd_state = l; data_in = d;
    @(posedge clk);
    if (!rst || soft_rst) begin
      q.delete();
      m_dout = '0;
      m_rem  = 0;
    end else begin
      do_rd = r && (q.size() != 0);
      do_wr = w && (q.size() < 16);
      if (do_rd) begin
        e = q.pop_front();
        m_dout = e[7:0];
        if (e[8]) m_rem = int'(e[7:2]) + 1;
        else if (m_rem != 0) m_rem = m_rem - 1;
      end
      if (do_wr) q.push_back({l, d});
    end
    #1;
    wr_en = 1'b0; rd_en = 1'b0; lfd_state = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h want=00", data_out); end
    total++; if (pkt_rem !== 7'd0) begin bad++; $display("FAIL reset_rem got=%0d want=0", pkt_rem); end
    rst = 1'b1;
    step(0, 0, 0, 0);
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 0, 8'(i));
      total++;
      if (full !== (i == 16)) begin bad++; $display("FAIL fill_full i=%0d got=%b want=%b", i, full, (i == 16)); end
    end
    step(1, 0, 0, 8'hFF);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL drop_full got=%b want=1", full); end
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 0, 0);
      total++;
      if (data_out !== 8'(i)) begin bad++; $display("FAIL drain_data i=%0d got=%h want=%h", i, data_out, 8'(i)); end
      total++;
      if (empty !== (i == 16)) begin bad++; $display("FAIL drain_empty i=%0d got=%b want=%b", i, empty, (i == 16)); end
    end
    total++; if (pkt_rem !== 7'd0) begin bad++; $display("FAIL drain_rem got=%0d want=0", pkt_rem); end
  endtask

  task automatic test_pkt_count();
    logic [7:0] bytes [5];
    bytes[0] = 8'h0C;
    for (int i = 1; i < 5; i++) bytes[i] = 8'($urandom);
    step(1, 0, 1, bytes[0]);
    for (int i = 1; i < 5; i++) step(1, 0, 0, bytes[i]);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0);
      total++;
      if (data_out !== bytes[i]) begin bad++; $display("FAIL pkt_data i=%0d got=%h want=%h", i, data_out, bytes[i]); end
      total++;
      if (pkt_rem !== 7'(4 - i)) begin bad++; $display("FAIL pkt_rem i=%0d got=%0d want=%0d", i, pkt_rem, 4 - i); end
    end
    step(0, 1, 0, 0);
    total++; if (data_out !== bytes[4]) begin bad++; $display("FAIL empty_read_hold got=%h want=%h", data_out, bytes[4]); end
    // Maximum length header: 63 payload bytes plus parity.
    step(1, 0, 1, 8'hFC);
    step(0, 1, 0, 0);
    total++; if (pkt_rem !== 7'd64) begin bad++; $display("FAIL pkt_rem_max got=%0d want=64", pkt_rem); end
  endtask

  task automatic test_simul_full();
    logic [7:0] vals [16];
    for (int i = 0; i < 16; i++) begin
      vals[i] = 8'($urandom);
      step(1, 0, 0, vals[i]);
    end
    step(1, 1, 0, 8'h5A);
    total++; if (data_out !== vals[0]) begin bad++; $display("FAIL simul_data got=%h want=%h", data_out, vals[0]); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL simul_full got=%b want=0", full); end
    for (int i = 1; i < 16; i++) begin
      step(0, 1, 0, 0);
      total++;
      if (data_out !== vals[i]) begin bad++; $display("FAIL simul_drain i=%0d got=%h want=%h", i, data_out, vals[i]); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL simul_occupancy got_empty=%b want=1", empty); end
  endtask

  task automatic test_soft_reset();
    step(1, 0, 1, 8'h14);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'($urandom));
    step(0, 1, 0, 0);
    total++; if (pkt_rem !== 7'd6) begin bad++; $display("FAIL soft_pre_rem got=%0d want=6", pkt_rem); end
    soft_rst = 1'b1;
    step(1, 1, 0, 8'h33);
    soft_rst = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL soft_empty got=%b want=1", empty); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL soft_dout got=%h want=00", data_out); end
    total++; if (pkt_rem !== 7'd0) begin bad++; $display("FAIL soft_rem got=%0d want=0", pkt_rem); end
    step(1, 0, 0, 8'hA5);
    step(0, 1, 0, 0);
    total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL soft_after got=%h want=a5", data_out); end
  endtask

  task automatic test_wrap();
    int occ = 1;
    int op;
    step(1, 0, 0, 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 2));
      if (occ == 1 && op == 1) op = 0;
      if (occ == 3 && op == 0) op = 1;
      step(op != 1, op != 0, 0, 8'($urandom));
      if (op == 0) occ++;
      if (op == 1) occ--;
      total++;
      if (data_out !== m_dout) begin bad++; $display("FAIL wrap_data i=%0d got=%h want=%h", i, data_out, m_dout); end
      total++;
      if (full !== 1'b0 || empty !== 1'b0) begin bad++; $display("FAIL wrap_flags i=%0d got=%b%b want=00", i, full, empty); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      soft_rst = ($urandom_range(0, 99) == 0);
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 9) == 0), 8'($urandom));
      soft_rst = 1'b0;
      total++;
      if (data_out !== m_dout || pkt_rem !== 7'(m_rem) ||
          empty !== (q.size() == 0) || full !== (q.size() == 16)) begin
        bad++;
        $display("FAIL random i=%0d got dout=%h rem=%0d e=%b f=%b want dout=%h rem=%0d e=%b f=%b",
                 i, data_out, pkt_rem, empty, full, m_dout, m_rem, (q.size() == 0), (q.size() == 16));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_pkt_count();
    test_simul_full();
    test_soft_reset();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
